// File: rtl/music_sequencer.sv
// rtl/music_sequencer.sv - music box playback controller stepping a note ROM at a fixed tempo
// Handles play, pause, stop, loop and end-of-song; note_out tracks the ROM two edges behind rom_addr.
module music_sequencer #(
  parameter int TICK_DIV  = 6_250_000,
  parameter int SONG0_LEN = 400,
  parameter int SONG1_LEN = 243,
  parameter int ADDR_W    = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic              song_sel,
  input  logic              loop_en,
  input  logic [7:0]        rom_note,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_sel,
  output logic [7:0]        note_out,
  output logic              busy,
  output logic              paused,
  output logic              done
);
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] LEN0 = ADDR_W'(SONG0_LEN);
  localparam logic [ADDR_W-1:0] LEN1 = ADDR_W'(SONG1_LEN);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE} state_t;

  state_t            state, state_nxt;
  logic [TICK_W-1:0] tick, tick_nxt;
  logic [ADDR_W-1:0] addr_nxt, length, last_addr;
  logic [1:0]        pipe_vld, pipe_nxt;
  logic              start, finish;

  // Length is held in ADDR_W bits, so a full 2^ADDR_W song wraps to 0 and last_addr still hits the top step.
  assign last_addr = length - ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick;
    addr_nxt  = rom_addr;
    pipe_nxt  = pipe_vld;
    start     = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        if (play) begin
          state_nxt = S_PLAY;
          start     = 1'b1;
        end
      end
      S_PLAY: begin
        pipe_nxt = {pipe_vld[0], 1'b1};
        if (tick == TICK_LAST) begin
          tick_nxt = '0;
          if (rom_addr < last_addr) begin
            addr_nxt = rom_addr + ADDR_W'(1);
          end else begin
            addr_nxt = '0;
            finish   = !loop_en;
          end
        end else begin
          tick_nxt = tick + TICK_W'(1);
        end
        if (stop) begin
          state_nxt = S_IDLE;
          finish    = 1'b0;
        end else if (finish) begin
          state_nxt = S_IDLE;
        end else if (pause) begin
          state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: begin
        // The ROM keeps clocking the frozen address, so the pipe stays valid for resume.
        pipe_nxt = {pipe_vld[0], 1'b1};
        if (stop)      state_nxt = S_IDLE;
        else if (play) state_nxt = S_PLAY;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (state_nxt == S_IDLE || start) begin
      tick_nxt = '0;
      addr_nxt = '0;
      pipe_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick     <= '0;
      rom_addr <= '0;
      rom_sel  <= 1'b0;
      length   <= LEN0;
      pipe_vld <= '0;
      note_out <= 8'd0;
      busy     <= 1'b0;
      paused   <= 1'b0;
      done     <= 1'b0;
    end else begin
      tick     <= tick_nxt;
      rom_addr <= addr_nxt;
      pipe_vld <= pipe_nxt;
      if (start) begin
        rom_sel <= song_sel;
        length  <= song_sel ? LEN1 : LEN0;
      end
      note_out <= (state_nxt == S_PLAY && pipe_nxt == 2'b11) ? rom_note : 8'd0;
      busy     <= (state_nxt != S_IDLE);
      paused   <= (state_nxt == S_PAUSE);
      done     <= finish;
    end
  end
endmodule

// File: tb/tb_music_sequencer.sv
// tb/tb_music_sequencer.sv - scoreboard bench for music_sequencer with a behavioural note ROM
module tb_music_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       play = 1'b0, pause = 1'b0, stop = 1'b0, song_sel = 1'b0, loop_en = 1'b0;
  logic [7:0] rom_note = 8'd0;
  logic [8:0] rom_addr;
  logic       rom_sel, busy, paused, done;
  logic [7:0] note_out;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [8:0] addr;
    logic [7:0] note;
    logic       busy;
    logic       paused;
    logic       done;
    logic       sel;
  } exp_t;
  exp_t sb[$];

  music_sequencer #(.TICK_DIV(4), .SONG0_LEN(400), .SONG1_LEN(243), .ADDR_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .play(play), .pause(pause), .stop(stop),
    .song_sel(song_sel), .loop_en(loop_en), .rom_note(rom_note),
    .rom_addr(rom_addr), .rom_sel(rom_sel), .note_out(note_out),
    .busy(busy), .paused(paused), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] song_note(input logic sel, input int a);
    if (!sel) begin
      if (a == 0) return 8'd34;
      if (a == 4) return 8'd39;
      if (a % 16 == 8) return 8'd0;
      return 8'((a * 7 + 3) % 61 + 1);
    end
    if (a == 0) return 8'd25;
    return 8'((a * 5 + 11) % 53 + 1);
  endfunction

  always @(posedge clk) rom_note <= song_note(rom_sel, int'(rom_addr));

  function automatic int exp_note(input logic sel, input int k, input int len);
    if (k < 2) return 0;
    return int'(song_note(sel, ((k - 2) / 4) % len));
  endfunction

  function automatic exp_t mk(input int c, input int a, input int n, input logic b,
                              input logic p, input logic d, input logic s);
    exp_t x;
    x.cyc = c; x.addr = 9'(a); x.note = 8'(n);
    x.busy = b; x.paused = p; x.done = d; x.sel = s;
    return x;
  endfunction

  task automatic tick_edge();
    @(posedge clk);
    #1;
    play = 1'b0; pause = 1'b0; stop = 1'b0;
    cyc++;
  endtask

  task automatic test_reset();
    repeat (3) tick_edge();
    checks++;
    if ({rom_addr, note_out, busy, paused, done, rom_sel} !== 22'd0) begin
      errors++;
      $display("FAIL reset_hold got addr=%0d note=%0d busy=%b paused=%b done=%b sel=%b want all 0",
               rom_addr, note_out, busy, paused, done, rom_sel);
    end
    rst_n = 1'b1;
    repeat (2) tick_edge();
    checks++;
    if ({rom_addr, note_out, busy, paused, done} !== 21'd0) begin
      errors++;
      $display("FAIL reset_idle got addr=%0d note=%0d busy=%b paused=%b done=%b want all 0",
               rom_addr, note_out, busy, paused, done);
    end
  endtask

  task automatic test_song0();
    exp_t e;
    int base = cyc + 1;
    song_sel = 1'b0; loop_en = 1'b0;
    for (int k = 0; k <= 20; k++) sb.push_back(mk(base + k, k / 4, exp_note(1'b0, k, 400), 1, 0, 0, 0));
    sb.push_back(mk(base + 21, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k <= 21; k++) begin
      if (k == 0) play = 1'b1;
      if (k == 21) stop = 1'b1;
      tick_edge();
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        checks++;
        if ({rom_addr, note_out, busy, paused, done, rom_sel} !== {e.addr, e.note, e.busy, e.paused, e.done, e.sel}) begin
          errors++;
          $display("FAIL song0 k=%0d got addr=%0d note=%0d busy=%b paused=%b done=%b sel=%b want addr=%0d note=%0d busy=%b paused=%b done=%b sel=%b",
                   k, rom_addr, note_out, busy, paused, done, rom_sel, e.addr, e.note, e.busy, e.paused, e.done, e.sel);
        end
      end
    end
  endtask

  task automatic test_pause();
    exp_t e;
    int base = cyc + 1;
    song_sel = 1'b0; loop_en = 1'b0;
    for (int k = 0; k <= 127; k++) begin
      if (k <= 20)       sb.push_back(mk(base + k, k / 4, exp_note(1'b0, k, 400), 1, 0, 0, 0));
      else if (k <= 120) sb.push_back(mk(base + k, 5, 0, 1, 1, 0, 0));
      else if (k <= 123) sb.push_back(mk(base + k, 5, song_note(1'b0, 5), 1, 0, 0, 0));
      else if (k <= 125) sb.push_back(mk(base + k, 6, song_note(1'b0, 5), 1, 0, 0, 0));
      else if (k == 126) sb.push_back(mk(base + k, 6, song_note(1'b0, 6), 1, 0, 0, 0));
      else               sb.push_back(mk(base + k, 0, 0, 0, 0, 0, 0));
    end
    for (int k = 0; k <= 127; k++) begin
      if (k == 0 || k == 121) play = 1'b1;
      if (k == 21 || k == 60) pause = 1'b1;
      if (k == 127) stop = 1'b1;
      tick_edge();
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        checks++;
        if ({rom_addr, note_out, busy, paused, done, rom_sel} !== {e.addr, e.note, e.busy, e.paused, e.done, e.sel}) begin
          errors++;
          $display("FAIL pause k=%0d got addr=%0d note=%0d busy=%b paused=%b done=%b sel=%b want addr=%0d note=%0d busy=%b paused=%b done=%b sel=%b",
                   k, rom_addr, note_out, busy, paused, done, rom_sel, e.addr, e.note, e.busy, e.paused, e.done, e.sel);
        end
      end
    end
  endtask

  task automatic test_priority();
    exp_t e;
    int base = cyc + 1;
    song_sel = 1'b0; loop_en = 1'b0;
    // Phase A: stop+pause+play at k=5. Phase B: play at k=10, pause+play at k=16, resume k=20, stop k=22.
    for (int k = 0; k <= 22; k++) begin
      if (k <= 4)        sb.push_back(mk(base + k, k / 4, exp_note(1'b0, k, 400), 1, 0, 0, 0));
      else if (k <= 9)   sb.push_back(mk(base + k, 0, 0, 0, 0, 0, 0));
      else if (k <= 15)  sb.push_back(mk(base + k, (k - 10) / 4, exp_note(1'b0, k - 10, 400), 1, 0, 0, 0));
      else if (k <= 19)  sb.push_back(mk(base + k, 1, 0, 1, 1, 0, 0));
      else if (k <= 21)  sb.push_back(mk(base + k, 1, song_note(1'b0, 1), 1, 0, 0, 0));
      else               sb.push_back(mk(base + k, 0, 0, 0, 0, 0, 0));
    end
    for (int k = 0; k <= 22; k++) begin
      if (k == 0 || k == 10 || k == 20) play = 1'b1;
      if (k == 5) begin stop = 1'b1; pause = 1'b1; play = 1'b1; end
      if (k == 16) begin pause = 1'b1; play = 1'b1; end
      if (k == 12) song_sel = 1'b1;
      if (k == 22) stop = 1'b1;
      tick_edge();
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        checks++;
        if ({rom_addr, note_out, busy, paused, done, rom_sel} !== {e.addr, e.note, e.busy, e.paused, e.done, e.sel}) begin
          errors++;
          $display("FAIL priority k=%0d got addr=%0d note=%0d busy=%b paused=%b done=%b sel=%b want addr=%0d note=%0d busy=%b paused=%b done=%b sel=%b",
                   k, rom_addr, note_out, busy, paused, done, rom_sel, e.addr, e.note, e.busy, e.paused, e.done, e.sel);
        end
      end
    end
    song_sel = 1'b0;
  endtask

  task automatic test_end_noloop();
    exp_t e;
    int base = cyc + 1;
    int done_cnt = 0;
    song_sel = 1'b1; loop_en = 1'b0;
    for (int k = 0; k <= 974; k++) begin
      if (k < 972)       sb.push_back(mk(base + k, k / 4, exp_note(1'b1, k, 243), 1, 0, 0, 1));
      else if (k == 972) sb.push_back(mk(base + k, 0, 0, 0, 0, 1, 1));
      else if (k == 973) sb.push_back(mk(base + k, 0, 0, 1, 0, 0, 1));
      else               sb.push_back(mk(base + k, 0, 0, 0, 0, 0, 1));
    end
    for (int k = 0; k <= 974; k++) begin
      if (k == 0 || k == 972 || k == 973) play = 1'b1;
      if (k == 974) stop = 1'b1;
      tick_edge();
      if (done === 1'b1) done_cnt++;
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        checks++;
        if ({rom_addr, note_out, busy, paused, done, rom_sel} !== {e.addr, e.note, e.busy, e.paused, e.done, e.sel}) begin
          errors++;
          $display("FAIL end_noloop k=%0d got addr=%0d note=%0d busy=%b paused=%b done=%b sel=%b want addr=%0d note=%0d busy=%b paused=%b done=%b sel=%b",
                   k, rom_addr, note_out, busy, paused, done, rom_sel, e.addr, e.note, e.busy, e.paused, e.done, e.sel);
        end
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL end_noloop_done_count got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_end_loop();
    exp_t e;
    int base = cyc + 1;
    int done_cnt = 0;
    song_sel = 1'b1; loop_en = 1'b1;
    for (int k = 0; k <= 980; k++) sb.push_back(mk(base + k, (k / 4) % 243, exp_note(1'b1, k, 243), 1, 0, 0, 1));
    sb.push_back(mk(base + 981, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k <= 981; k++) begin
      if (k == 0) play = 1'b1;
      if (k == 981) stop = 1'b1;
      tick_edge();
      if (done === 1'b1) done_cnt++;
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        checks++;
        if ({rom_addr, note_out, busy, paused, done, rom_sel} !== {e.addr, e.note, e.busy, e.paused, e.done, e.sel}) begin
          errors++;
          $display("FAIL end_loop k=%0d got addr=%0d note=%0d busy=%b paused=%b done=%b sel=%b want addr=%0d note=%0d busy=%b paused=%b done=%b sel=%b",
                   k, rom_addr, note_out, busy, paused, done, rom_sel, e.addr, e.note, e.busy, e.paused, e.done, e.sel);
        end
      end
    end
    checks++;
    if (done_cnt !== 0) begin
      errors++;
      $display("FAIL end_loop_done_count got %0d want 0", done_cnt);
    end
    loop_en = 1'b0; song_sel = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    int base = cyc + 1;
    song_sel = 1'b0; loop_en = 1'b0;
    for (int k = 0; k <= 410; k++) begin
      if (k <= 401) sb.push_back(mk(base + k, k / 4, exp_note(1'b0, k, 400), 1, 0, 0, 0));
      else          sb.push_back(mk(base + k, 100, 0, 1, 1, 0, 0));
    end
    for (int k = 0; k <= 410; k++) begin
      if (k == 0) play = 1'b1;
      if (k == 402) pause = 1'b1;
      tick_edge();
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        checks++;
        if ({rom_addr, note_out, busy, paused, done, rom_sel} !== {e.addr, e.note, e.busy, e.paused, e.done, e.sel}) begin
          errors++;
          $display("FAIL async_pre k=%0d got addr=%0d note=%0d busy=%b paused=%b done=%b sel=%b want addr=%0d note=%0d busy=%b paused=%b done=%b sel=%b",
                   k, rom_addr, note_out, busy, paused, done, rom_sel, e.addr, e.note, e.busy, e.paused, e.done, e.sel);
        end
      end
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if ({rom_addr, note_out, busy, paused, done, rom_sel} !== 22'd0) begin
      errors++;
      $display("FAIL async_immediate got addr=%0d note=%0d busy=%b paused=%b done=%b sel=%b want all 0",
               rom_addr, note_out, busy, paused, done, rom_sel);
    end
    #3;
    rst_n = 1'b1;
    base = cyc + 1;
    for (int k = 0; k <= 5; k++) sb.push_back(mk(base + k, k / 4, exp_note(1'b0, k, 400), 1, 0, 0, 0));
    sb.push_back(mk(base + 6, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k <= 6; k++) begin
      if (k == 0) play = 1'b1;
      if (k == 6) stop = 1'b1;
      tick_edge();
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        checks++;
        if ({rom_addr, note_out, busy, paused, done, rom_sel} !== {e.addr, e.note, e.busy, e.paused, e.done, e.sel}) begin
          errors++;
          $display("FAIL async_restart k=%0d got addr=%0d note=%0d busy=%b paused=%b done=%b sel=%b want addr=%0d note=%0d busy=%b paused=%b done=%b sel=%b",
                   k, rom_addr, note_out, busy, paused, done, rom_sel, e.addr, e.note, e.busy, e.paused, e.done, e.sel);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_song0();
    test_pause();
    test_priority();
    test_end_noloop();
    test_end_loop();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries left want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
